// File: rtl/param_bus_arbiter_if.sv
// rtl/param_bus_arbiter_if.sv - requester and param-PIO Avalon bus bundle for param_bus_arbiter
interface param_bus_arbiter_if #(
    parameter int NREQ = 2,
    parameter int NSLV = 4,
    parameter int SELW = 2,
    parameter int DW   = 32
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0]      req_write;
    logic [NREQ*SELW-1:0] req_sel;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      ack;
    logic [DW-1:0]        rdata;
    logic                 err;
    logic [NSLV-1:0]      av_chipselect;
    logic [1:0]           av_address;
    logic                 av_write_n;
    logic [DW-1:0]        av_writedata;
    logic [NSLV*DW-1:0]   av_readdata;

    modport master (
        input  req, req_write, req_sel, req_wdata, av_readdata,
        output ack, rdata, err, av_chipselect, av_address, av_write_n, av_writedata
    );

    modport slave (
        output req, req_write, req_sel, req_wdata, av_readdata,
        input  ack, rdata, err, av_chipselect, av_address, av_write_n, av_writedata
    );
endinterface

// File: rtl/param_bus_arbiter.sv
// rtl/param_bus_arbiter.sv - round-robin arbiter sharing the param PIO Avalon bus
module param_bus_arbiter #(
    parameter int NREQ = 2,
    parameter int NSLV = 4,
    parameter int SELW = 2,
    parameter int DW   = 32
) (
    input  logic                clk,
    input  logic                reset_n,
    param_bus_arbiter_if.master bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   last_q, last_d;
    logic [IW-1:0]   win_q, win_d;
    logic            wr_q, wr_d;
    logic [SELW-1:0] sel_q, sel_d;
    logic            gnt;

    logic [NREQ-1:0] ack_q, ack_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [NSLV-1:0] cs_q, cs_d;
    logic            write_n_q, write_n_d;
    logic [DW-1:0]   writedata_q, writedata_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            last_q      <= IW'(NREQ - 1);
            win_q       <= '0;
            wr_q        <= 1'b0;
            sel_q       <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            cs_q        <= '0;
            write_n_q   <= 1'b1;
            writedata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            win_q       <= win_d;
            wr_q        <= wr_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cs_q        <= cs_d;
            write_n_q   <= write_n_d;
            writedata_q <= writedata_d;
        end
    end

    // Round-robin search starts one past the last winner and wraps.
    always_comb begin
        int idx;
        idx     = 0;
        gnt     = 1'b0;
        state_d = state_q;
        last_d  = last_q;
        win_d   = win_q;
        wr_d    = wr_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = int'(last_q) + k;
                    if (idx >= NREQ) idx = idx - NREQ;
                    if (!gnt && bus.req[idx]) begin
                        gnt   = 1'b1;
                        win_d = IW'(idx);
                    end
                end
                if (gnt) begin
                    wr_d    = bus.req_write[win_d];
                    sel_d   = bus.req_sel[int'(win_d)*SELW +: SELW];
                    last_d  = win_d;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs; the bus is driven in ISSUE, ack in DONE.
    always_comb begin
        cs_d        = '0;
        write_n_d   = 1'b1;
        writedata_d = writedata_q;
        ack_d       = '0;
        err_d       = 1'b0;
        rdata_d     = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (gnt) begin
                    writedata_d = bus.req_wdata[int'(win_d)*DW +: DW];
                    if (int'(sel_d) < NSLV) begin
                        for (int k = 0; k < NSLV; k++) cs_d[k] = (sel_d == SELW'(k));
                        write_n_d = ~wr_d;
                    end
                end
            end
            S_ISSUE: begin
                ack_d[win_q] = 1'b1;
                if (int'(sel_q) >= NSLV) begin
                    err_d = 1'b1;
                    if (!wr_q) rdata_d = '0;
                end else if (!wr_q) begin
                    for (int k = 0; k < NSLV; k++)
                        if (sel_q == SELW'(k)) rdata_d = bus.av_readdata[k*DW +: DW];
                end
            end
            default: ;
        endcase
    end

    assign bus.ack           = ack_q;
    assign bus.rdata         = rdata_q;
    assign bus.err           = err_q;
    assign bus.av_chipselect = cs_q;
    assign bus.av_address    = 2'b00;
    assign bus.av_write_n    = write_n_q;
    assign bus.av_writedata  = writedata_q;
endmodule

// File: tb/tb_param_bus_arbiter.sv
// tb/tb_param_bus_arbiter.sv - scoreboard bench for param_bus_arbiter
module tb_param_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    param_bus_arbiter_if #(.NREQ(2), .NSLV(3), .SELW(2), .DW(32)) bus ();

    param_bus_arbiter #(.NREQ(2), .NSLV(3), .SELW(2), .DW(32)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    logic [31:0] slv [3] = '{32'hA000_0000, 32'hA000_0001, 32'hA000_0002};
    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (bus.av_chipselect[k] && !bus.av_write_n) slv[k] <= bus.av_writedata;
    assign bus.av_readdata = {slv[2], slv[1], slv[0]};

    typedef struct packed {logic [2:0] cs; logic wn; logic [31:0] wd;} bus_t;
    typedef struct packed {logic [1:0] ack; logic [31:0] rd; logic err;} ack_t;

    bus_t bus_q[$];
    ack_t ack_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon_bus
        bus_t e;
        if (reset_n && bus.av_chipselect != 3'b000) begin
            chk("cs_onehot", $countones(bus.av_chipselect), 1);
            if (bus_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL bus_unexpected: got cs=%b expected none", bus.av_chipselect);
            end else begin
                e = bus_q.pop_front();
                chk("bus_cs", {29'd0, bus.av_chipselect}, {29'd0, e.cs});
                chk("bus_write_n", {31'd0, bus.av_write_n}, {31'd0, e.wn});
                chk("bus_writedata", bus.av_writedata, e.wd);
            end
        end
    end

    always @(negedge clk) begin : mon_ack
        ack_t e;
        if (reset_n && bus.ack != 2'b00) begin
            chk("ack_onehot", $countones(bus.ack), 1);
            if (ack_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL ack_unexpected: got ack=%b expected none", bus.ack);
            end else begin
                e = ack_q.pop_front();
                chk("ack_vec", {30'd0, bus.ack}, {30'd0, e.ack});
                chk("rdata", bus.rdata, e.rd);
                chk("err", {31'd0, bus.err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_txn(input int i, input bit w, input int s, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input bit mutate);
        int n;
        bit got;
        if (s < 3) bus_q.push_back('{cs: 3'(1 << s), wn: ~w, wd: wd});
        ack_q.push_back('{ack: 2'(1 << i), rd: exp_rd, err: (s >= 3)});
        @(posedge clk); #1;
        bus.req_write[i]          = w;
        bus.req_sel[i*2 +: 2]     = 2'(s);
        bus.req_wdata[i*32 +: 32] = wd;
        bus.req[i]                = 1'b1;
        got = 1'b0;
        n = 0;
        while (!got && n < 10) begin
            @(negedge clk);
            n++;
            if (mutate && n == 2) bus.req_wdata[i*32 +: 32] = 32'hDEAD_BEEF;
            if (bus.ack[i]) got = 1'b1;
        end
        bus.req[i] = 1'b0;
        chk("ack_latency", n, 3);
    endtask

    initial begin
        int n, nack;
        int t[4];
        bus.req = '0;
        bus.req_write = '0;
        bus.req_sel = '0;
        bus.req_wdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {30'd0, bus.ack}, 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        chk("rst_cs", {29'd0, bus.av_chipselect}, 32'd0);
        chk("rst_write_n", {31'd0, bus.av_write_n}, 32'd1);
        chk("rst_writedata", bus.av_writedata, 32'd0);
        chk("rst_address", {30'd0, bus.av_address}, 32'd0);
        reset_n = 1'b1;

        do_txn(0, 1'b1, 1, 32'h0000_1234, 32'h0, 1'b0);
        do_txn(1, 1'b0, 1, 32'h0, 32'h0000_1234, 1'b0);

        // contention: requester 0 writes slave 0, requester 1 reads it back
        bus_q.push_back('{cs: 3'b001, wn: 1'b0, wd: 32'h11});
        bus_q.push_back('{cs: 3'b001, wn: 1'b1, wd: 32'h0});
        bus_q.push_back('{cs: 3'b001, wn: 1'b0, wd: 32'h11});
        bus_q.push_back('{cs: 3'b001, wn: 1'b1, wd: 32'h0});
        ack_q.push_back('{ack: 2'b01, rd: 32'h1234, err: 1'b0});
        ack_q.push_back('{ack: 2'b10, rd: 32'h11, err: 1'b0});
        ack_q.push_back('{ack: 2'b01, rd: 32'h11, err: 1'b0});
        ack_q.push_back('{ack: 2'b10, rd: 32'h11, err: 1'b0});
        @(posedge clk); #1;
        bus.req_write = 2'b01;
        bus.req_sel = 4'b0000;
        bus.req_wdata = {32'h0, 32'h11};
        bus.req = 2'b11;
        n = 0;
        nack = 0;
        while (nack < 4 && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.ack != 2'b00) begin
                t[nack] = n;
                nack++;
            end
        end
        bus.req = 2'b00;
        chk("contention_acks", nack, 4);
        for (int k = 1; k < 4; k++) chk("contention_gap", t[k] - t[k-1], 3);

        do_txn(0, 1'b0, 3, 32'h0, 32'h0, 1'b0);
        do_txn(1, 1'b1, 2, 32'h0000_5678, 32'h0, 1'b1);
        do_txn(0, 1'b0, 2, 32'h0, 32'h0000_5678, 1'b0);

        // reset while the bus is driven: transaction abandoned, no ack
        bus_q.push_back('{cs: 3'b001, wn: 1'b0, wd: 32'h99});
        @(posedge clk); #1;
        bus.req_write[1] = 1'b1;
        bus.req_sel[3:2] = 2'd0;
        bus.req_wdata[63:32] = 32'h99;
        bus.req[1] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("pre_reset_cs", {29'd0, bus.av_chipselect}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_cs", {29'd0, bus.av_chipselect}, 32'd0);
        chk("mid_reset_write_n", {31'd0, bus.av_write_n}, 32'd1);
        chk("mid_reset_ack", {30'd0, bus.ack}, 32'd0);
        chk("mid_reset_writedata", bus.av_writedata, 32'd0);
        bus.req = 2'b00;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        bus_q.push_back('{cs: 3'b001, wn: 1'b1, wd: 32'h0});
        ack_q.push_back('{ack: 2'b01, rd: 32'h11, err: 1'b0});
        @(posedge clk); #1;
        bus.req_write = 2'b10;
        bus.req_sel = 4'b1000;
        bus.req_wdata = {32'h77, 32'h0};
        bus.req = 2'b11;
        n = 0;
        while (bus.ack == 2'b00 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("post_reset_first", {30'd0, bus.ack}, 32'd1);
        bus.req = 2'b00;

        repeat (6) @(negedge clk);
        chk("bus_q_drained", bus_q.size(), 0);
        chk("ack_q_drained", ack_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
